// File: rtl/inductive_state_pkg.sv
// inductive_state_pkg: shared FSM encoding and channel slicing for the inductive-state tap
package inductive_state_pkg;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_HOLD} tap_state_e;

    function automatic int ch_lo(input int idx, input int ch_w);
        return idx * ch_w;
    endfunction

endpackage

// File: rtl/inductive_state_tap_if.sv
// inductive_state_tap_if: harness-side (master) and tap-side (slave) view of the tapped state bus
interface inductive_state_tap_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 32,
    parameter int CNT_W  = 8
) ();
    logic [NUM_CH*CH_W-1:0] state_in;
    logic [NUM_CH-1:0]      ch_mask;
    logic                   flush;
    logic                   snap_req;
    logic                   snap_release;
    logic [NUM_CH*CH_W-1:0] state_src;
    logic                   src_valid;
    logic                   snap_held;
    logic [CNT_W-1:0]       stable_cnt;

    modport master (
        output state_in, ch_mask, flush, snap_req, snap_release,
        input  state_src, src_valid, snap_held, stable_cnt
    );

    modport slave (
        input  state_in, ch_mask, flush, snap_req, snap_release,
        output state_src, src_valid, snap_held, stable_cnt
    );
endinterface

// File: rtl/inductive_state_delay_line.sv
// inductive_state_delay_line: free-running DEPTH-stage shift register with sync flush; DEPTH==0 is a wire
module inductive_state_delay_line #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clock, reset_n, flush};
        assign dout = din;
    end else begin : g_reg
        logic [DEPTH-1:0][WIDTH-1:0] stage;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                stage <= '0;
            end else if (flush) begin
                stage <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end
        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/inductive_state_tap.sv
// inductive_state_tap: delayed, maskable, freezable export of core state with a stability counter
module inductive_state_tap
    import inductive_state_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 32,
    parameter int DELAY  = 2,
    parameter int CNT_W  = 8
) (
    input logic                  clock,
    input logic                  reset_n,
    inductive_state_tap_if.slave bus
);
    localparam int W  = NUM_CH * CH_W;
    localparam int FW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam tap_state_e       ST_INIT   = (DELAY == 0) ? ST_RUN : ST_FILL;
    localparam logic [FW-1:0]    FILL_LAST = FW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    tap_state_e       state;
    logic [FW-1:0]    fill_cnt;
    logic [W-1:0]     delayed, snap, raw_src, masked, prev;
    logic [CNT_W-1:0] cnt;
    logic             valid;

    inductive_state_delay_line #(.WIDTH(W), .DEPTH(DELAY)) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (bus.flush),
        .din     (bus.state_in),
        .dout    (delayed)
    );

    // Raw data is stored everywhere; the mask is applied only here so mask edits act immediately.
    assign raw_src = (state == ST_HOLD) ? snap : delayed;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_mask
        assign masked[ch_lo(c, CH_W) +: CH_W] = bus.ch_mask[c] ? raw_src[ch_lo(c, CH_W) +: CH_W] : '0;
    end

    assign valid          = (state != ST_FILL);
    assign bus.state_src  = masked;
    assign bus.src_valid  = valid;
    assign bus.snap_held  = (state == ST_HOLD);
    assign bus.stable_cnt = cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            fill_cnt <= '0;
            snap     <= '0;
        end else if (bus.flush) begin
            state    <= ST_INIT;
            fill_cnt <= '0;
            snap     <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == FILL_LAST) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.snap_req) begin
                        state <= ST_HOLD;
                        snap  <= delayed;
                    end
                end
                ST_HOLD: if (bus.snap_release) state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Compares the masked output, so a mask change restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= masked;
            cnt  <= (valid && masked == prev) ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1) : '0;
        end
    end
endmodule
